// File: rtl/wb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : wb_uart_tx
//  Purpose  : Wishbone-classic slave with a transmit-only UART (8N1) and a
//             small TX FIFO. Register window of 16 bytes at BASE_ADDR:
//               0x0 DATA   (W)  push byte [7:0] when sel[0]=1, reads 0
//               0x4 STATUS (R)  [0] busy [1] full [2] empty [3] overflow
//                               [12:8] FIFO count; write 1 to [3] clears ovf
//               0x8 DIV    (RW) [15:0] bit period minus one
//               0xC CTRL   (RW) [0] enable [1] irq_en
//  Ports    : wb_clk_i / wb_rst_i          clock, synchronous active-high reset
//             wbs_stb_i/cyc_i/we_i/sel_i   Wishbone request qualifiers
//             wbs_adr_i / wbs_dat_i        byte address / write data
//             wbs_ack_o / wbs_dat_o        one-cycle acknowledge / read data
//             uart_tx_o                    serial line (idle high)
//             uart_tx_oeb_o                active-low pad output enable
//             irq_o                        level interrupt: FIFO drained
//  Revision : 1.0  initial release
// ============================================================================
module wb_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        uart_tx_o,
  output logic        uart_tx_oeb_o,
  output logic        irq_o
);

  localparam int          PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'd433;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Bus front end. The request is captured in the hit cycle and its write
  // effect is applied at the end of the ack cycle, so register side effects
  // never depend on the master holding its signals past ack.
  // --------------------------------------------------------------------------
  logic        hit;
  logic        req_we;
  logic [1:0]  req_off;
  logic [1:0]  req_sel;
  logic [15:0] req_dat;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
  assign unused_bits = ^{wbs_dat_i[31:16], wbs_adr_i[1:0], wbs_sel_i[3:2]};

  // Register state
  logic [15:0] div;
  logic        enable;
  logic        irq_en;
  logic        overflow;

  // FIFO state
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       count;
  logic             full;
  logic             empty;
  logic [7:0]       head;

  // Transmitter state
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] div_lat, div_lat_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  tx_byte, tx_byte_n;
  logic        tx_n;
  logic        pop;
  logic        busy;
  logic        bit_done;

  assign full  = (count == DEPTH_C);
  assign empty = (count == 5'd0);
  assign head  = mem[rd_ptr];
  assign busy  = (state != S_IDLE);

  // Write decode, all qualified by the ack cycle
  logic wr;
  logic push;
  logic push_ok;
  logic ovf_clr;

  assign wr      = wbs_ack_o & req_we;
  assign push    = wr & (req_off == 2'd0) & req_sel[0];
  // A full FIFO still accepts the byte when the transmitter frees a slot
  // in the same cycle.
  assign push_ok = push & (~full | pop);
  assign ovf_clr = wr & (req_off == 2'd1) & req_sel[0] & req_dat[3];

  always_comb begin
    rd_data = 32'd0;
    case (wbs_adr_i[3:2])
      2'd1:    rd_data = {19'd0, count, 4'd0, overflow, empty, full, busy};
      2'd2:    rd_data = {16'd0, div};
      2'd3:    rd_data = {30'd0, irq_en, enable};
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      req_we    <= 1'b0;
      req_off   <= 2'd0;
      req_sel   <= 2'd0;
      req_dat   <= 16'd0;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit & ~wbs_we_i) ? rd_data : 32'd0;
      if (hit) begin
        req_we  <= wbs_we_i;
        req_off <= wbs_adr_i[3:2];
        req_sel <= wbs_sel_i[1:0];
        req_dat <= wbs_dat_i[15:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Configuration registers
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div      <= DIV_RST;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr && req_off == 2'd2) begin
        if (req_sel[0]) div[7:0]  <= req_dat[7:0];
        if (req_sel[1]) div[15:8] <= req_dat[15:8];
      end
      if (wr && req_off == 2'd3 && req_sel[0]) begin
        enable <= req_dat[0];
        irq_en <= req_dat[1];
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO. Storage carries no reset; only the pointers and count do.
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= req_dat[7:0];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM. Each bit runs cnt from 0 to div_lat, where div_lat is a
  // snapshot of DIV taken as the bit begins. The line output is registered
  // from the next-state values so it switches together with the state.
  // --------------------------------------------------------------------------
  assign bit_done = (cnt == div_lat);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    div_lat_n = div_lat;
    bit_idx_n = bit_idx;
    tx_byte_n = tx_byte;
    tx_n      = uart_tx_o;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = 16'd0;
        tx_n  = 1'b1;
        if (enable && !empty) begin
          pop       = 1'b1;
          state_n   = S_START;
          tx_byte_n = head;
          div_lat_n = div;
          tx_n      = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_n   = S_DATA;
          cnt_n     = 16'd0;
          bit_idx_n = 3'd0;
          div_lat_n = div;
          tx_n      = tx_byte[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_n     = 16'd0;
          div_lat_n = div;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = tx_byte[bit_idx + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_n     = 16'd0;
          div_lat_n = div;
          // Chain straight into the next frame so back-to-back bytes leave
          // no idle gap on the line.
          if (enable && !empty) begin
            pop       = 1'b1;
            state_n   = S_START;
            tx_byte_n = head;
            tx_n      = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      div_lat   <= 16'd0;
      bit_idx   <= 3'd0;
      tx_byte   <= 8'd0;
      uart_tx_o <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      div_lat   <= div_lat_n;
      bit_idx   <= bit_idx_n;
      tx_byte   <= tx_byte_n;
      uart_tx_o <= tx_n;
    end
  end

  // Pad enable and interrupt outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      uart_tx_oeb_o <= 1'b1;
      irq_o         <= 1'b0;
    end else begin
      uart_tx_oeb_o <= ~enable;
      irq_o         <= irq_en & empty & ~busy;
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_uart_tx.md
WB_UART_TX -- requirements
Module: wb_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning base of the 16-byte register window (bits [3:0] ignored).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries (power of 2, 2..16).
REQ-003 SHALL have one clock and one reset: the clock is wb_clk_i and the reset is wb_rst_i, synchronous and active-high.
REQ-004 SHALL have port wb_clk_i  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port wb_rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic slave strobe, cycle and write-enable.
REQ-007 SHALL have port wbs_sel_i  input  4  byte selects.
REQ-008 SHALL have ports wbs_dat_i and wbs_adr_i  input  32 each  write data and byte address.
REQ-009 SHALL have port wbs_ack_o  output  1  transfer acknowledge.
REQ-010 SHALL have port wbs_dat_o  output  32  read data.
REQ-011 SHALL have port uart_tx_o  output  1  serial line, routed to one io_out pad bit.
REQ-012 SHALL have port uart_tx_oeb_o  output  1  active-low pad output enable, routed to the matching io_oeb bit.
REQ-013 SHALL have port irq_o  output  1  level interrupt, routed to a user_irq bit.

Function
REQ-014 SHALL decode hit = stb & cyc & (adr[31:4] == BASE_ADDR[31:4]) & ~ack; ack pulses high exactly one cycle, the cycle after hit; a miss is never acknowledged.
REQ-015 SHALL drive wbs_dat_o with registered read data during ack, and 0 otherwise.
REQ-016 SHALL implement DATA at offset 0x0: a write with sel[0]=1 pushes wbs_dat_i[7:0] into the FIFO; reads return 0.
REQ-017 SHALL implement STATUS at offset 0x4 (read): [0] busy (FSM not IDLE), [1] full, [2] empty, [3] sticky overflow, [8 +: 5] FIFO count; writing 1 to bit 3 clears overflow.
REQ-018 SHALL implement DIV at offset 0x8: R/W [15:0]; bit period = DIV+1 clocks; DIV=0 gives 1 clock per bit.
REQ-019 SHALL implement CTRL at offset 0xC: R/W [0] enable, [1] irq_en.
REQ-020 SHALL take each write effect in the ack cycle; unused register bits read 0.
REQ-021 SHALL, on a DATA push while full, drop the byte and set overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-022 SHALL implement FSM states IDLE, START, DATA, STOP: each bit lasts DIV+1 cycles, with DIV sampled at each bit start.
REQ-023 SHALL pop in IDLE when enable=1 and the FIFO is non-empty, then enter START on the next cycle.
REQ-024 SHALL transition START->DATA; DATA sends 8 bits LSB first; DATA->STOP.
REQ-025 SHALL, at STOP end, go to START with a pop if enable=1 and the FIFO is non-empty (no idle gap); otherwise go to IDLE.
REQ-026 SHALL drive uart_tx_o=1 in IDLE/STOP, 0 in START, and the current data bit in DATA.
REQ-027 SHALL, for a DATA write acked in cycle N with IDLE, enable=1 and FIFO empty, pop in N+1 and drive uart_tx_o low from N+2.
REQ-028 SHALL, when enable is cleared mid-frame, complete the current frame, then idle; FIFO contents are retained.
REQ-029 SHALL set uart_tx_oeb_o = ~enable (registered).
REQ-030 SHALL set irq_o = irq_en & empty & ~busy (registered).

Reset
REQ-031 SHALL, while wb_rst_i=1 at a clock edge, set: FSM IDLE, FIFO empty, overflow 0, DIV=16'd433, CTRL=0, wbs_ack_o=0, wbs_dat_o=0, uart_tx_o=1, uart_tx_oeb_o=1, irq_o=0.
REQ-032 SHALL, on reset mid-frame, abort the frame; uart_tx_o returns to 1 in the cycle after the reset edge.

Verification
REQ-033 SHALL be covered by: reset then read STATUS/DIV/CTRL -> 0x0000_0004, 0x0000_01B1, 0x0; single ack each.
REQ-034 SHALL be covered by: DIV=3, CTRL=1, write 0xA5 -> line low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; busy=0 afterward.
REQ-035 SHALL be covered by: CTRL=0, push 9 bytes with FIFO_DEPTH=8 -> count=8, full=1, overflow=1; write STATUS 0x8 -> overflow=0.
REQ-036 SHALL be covered by: DIV=0, push 3 bytes, enable -> 30 contiguous bit-cycles with no idle gap between frames; irq_o rises after the last stop bit when irq_en=1.
REQ-037 SHALL be covered by: wb_rst_i pulse mid-DATA -> uart_tx_o=1 next cycle, count=0, uart_tx_oeb_o=1.
REQ-038 SHALL be covered by: access at BASE_ADDR+0x10 -> no ack over 10 cycles; registers unchanged.
